// File: rtl/sdm_codec_array_if.sv
// Sample-path bundle for sdm_codec_array: PCM/bitstream strobes and data in both directions.
// master = audio/pin side driving the codec, slave = the codec itself.
interface sdm_codec_array_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16
);
    logic [CHANNELS-1:0]        valid_in_dac;
    logic [CHANNELS*DATA_W-1:0] audio_in;
    logic [CHANNELS-1:0]        valid_out_dac;
    logic [CHANNELS-1:0]        sdm_out;
    logic [CHANNELS-1:0]        valid_in_adc;
    logic [CHANNELS-1:0]        sdm_in;
    logic [CHANNELS-1:0]        valid_out_adc;
    logic [CHANNELS*DATA_W-1:0] audio_out;

    modport master (
        output valid_in_dac, audio_in, valid_in_adc, sdm_in,
        input  valid_out_dac, sdm_out, valid_out_adc, audio_out
    );

    modport slave (
        input  valid_in_dac, audio_in, valid_in_adc, sdm_in,
        output valid_out_dac, sdm_out, valid_out_adc, audio_out
    );
endinterface

// File: rtl/sdm_codec_array.sv
// Multi-channel first-order sigma-delta modulators plus boxcar decimating demodulators.
// Optional SDM_LOOPBACK_EN adds a loopback input routing each modulator into its demodulator.
module sdm_codec_array #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int DECIM    = 64
) (
    input  logic clk,
    input  logic rst,
    sdm_codec_array_if.slave bus
`ifdef SDM_LOOPBACK_EN
    ,
    input  logic loopback
`endif
);
    localparam int LOG2_D = $clog2(DECIM);

    localparam logic signed [DATA_W+1:0] FB_POS = {3'b001, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W+1:0] FB_NEG = {3'b111, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]        PCM_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]        MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [LOG2_D-1:0]        CNT_LAST = LOG2_D'(DECIM - 1);

    generate
        if (DECIM < 2 || (DECIM & (DECIM - 1)) != 0 || DECIM > 2 ** (DATA_W - 1)) begin : g_bad_decim
            $error("sdm_codec_array: DECIM must be a power of two in [2, 2**(DATA_W-1)]");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic signed [DATA_W+1:0] acc_q, acc_d;
            logic signed [DATA_W+1:0] x_ext;
            logic                     b_q, b_d;
            logic                     vdac_q;

            always_comb begin
                x_ext = {{2{bus.audio_in[gi*DATA_W + DATA_W - 1]}}, bus.audio_in[gi*DATA_W +: DATA_W]};
                acc_d = acc_q;
                b_d   = b_q;
                if (bus.valid_in_dac[gi]) begin
                    acc_d = acc_q + x_ext - (b_q ? FB_POS : FB_NEG);
                    b_d   = ~acc_d[DATA_W+1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q  <= '0;
                    b_q    <= 1'b0;
                    vdac_q <= 1'b0;
                end else begin
                    acc_q  <= acc_d;
                    b_q    <= b_d;
                    vdac_q <= bus.valid_in_dac[gi];
                end
            end

            assign bus.sdm_out[gi]       = b_q;
            assign bus.valid_out_dac[gi] = vdac_q;

            logic              bit_in, stb_in;
            logic [LOG2_D:0]   ones_q, ones_d, ones_fin;
            logic [LOG2_D-1:0] cnt_q, cnt_d;
            logic [DATA_W-1:0] aout_q, aout_d;
            logic [DATA_W-1:0] shifted;
            logic              last;

`ifdef SDM_LOOPBACK_EN
            assign bit_in = loopback ? b_q    : bus.sdm_in[gi];
            assign stb_in = loopback ? vdac_q : bus.valid_in_adc[gi];
`else
            assign bit_in = bus.sdm_in[gi];
            assign stb_in = bus.valid_in_adc[gi];
`endif

            // Offset-binary to two's complement is an MSB flip; a full window (MSB of ones set) saturates.
            always_comb begin
                ones_fin = ones_q + {{LOG2_D{1'b0}}, bit_in};
                shifted  = {ones_fin[LOG2_D-1:0], {(DATA_W-LOG2_D){1'b0}}};
                last     = stb_in && (cnt_q == CNT_LAST);
                ones_d   = ones_q;
                cnt_d    = cnt_q;
                aout_d   = aout_q;
                if (stb_in) begin
                    if (last) begin
                        ones_d = '0;
                        cnt_d  = '0;
                        aout_d = ones_fin[LOG2_D] ? PCM_MAX : (shifted ^ MSB_MASK);
                    end else begin
                        ones_d = ones_fin;
                        cnt_d  = cnt_q + LOG2_D'(1);
                    end
                end
            end

            logic vadc_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ones_q <= '0;
                    cnt_q  <= '0;
                    aout_q <= '0;
                    vadc_q <= 1'b0;
                end else begin
                    ones_q <= ones_d;
                    cnt_q  <= cnt_d;
                    aout_q <= aout_d;
                    vadc_q <= last;
                end
            end

            assign bus.valid_out_adc[gi]                = vadc_q;
            assign bus.audio_out[gi*DATA_W +: DATA_W]   = aout_q;
        end
    endgenerate
endmodule

// File: tb/tb_sdm_codec_array.sv
// Directed self-checking bench for sdm_codec_array (default 2x16/64 and a 4x12/16 instance).
module tb_sdm_codec_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SDM_LOOPBACK_EN
    logic loopback = 1'b0;
`endif

    always #5 clk = ~clk;

    sdm_codec_array_if #(.CHANNELS(2), .DATA_W(16)) bus ();
    sdm_codec_array_if #(.CHANNELS(4), .DATA_W(12)) bus2 ();

    sdm_codec_array #(.CHANNELS(2), .DATA_W(16), .DECIM(64)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef SDM_LOOPBACK_EN
        ,
        .loopback(loopback)
`endif
    );

    sdm_codec_array #(.CHANNELS(4), .DATA_W(12), .DECIM(16)) dut2 (
        .clk(clk),
        .rst(rst),
        .bus(bus2)
`ifdef SDM_LOOPBACK_EN
        ,
        .loopback(1'b0)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid_in_dac  = '0;
        bus.audio_in      = '0;
        bus.valid_in_adc  = '0;
        bus.sdm_in        = '0;
        bus2.valid_in_dac = '0;
        bus2.audio_in     = '0;
        bus2.valid_in_adc = '0;
        bus2.sdm_in       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic int a0();
        logic signed [15:0] v;
        v = bus.audio_out[15:0];
        return int'(v);
    endfunction

    function automatic int a1();
        logic signed [15:0] v;
        v = bus.audio_out[31:16];
        return int'(v);
    endfunction

    task automatic demod_window(input string tag, input int mode, input int exp_val);
        int pulses   = 0;
        int pulse_at = -1;
        int val      = 0;
        do_reset();
        for (int k = 0; k < 64; k++) begin
            bus.valid_in_adc[0] = 1'b1;
            bus.sdm_in[0] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((k % 2) == 0);
            tick();
            if (bus.valid_out_adc[0]) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
                val = a0();
            end
        end
        bus.valid_in_adc[0] = 1'b0;
        tick();
        if (bus.valid_out_adc[0]) pulses++;
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_at"}, pulse_at, 63);
        check({tag, "_val"}, val, exp_val);
        check({tag, "_hold"}, a0(), exp_val);
        $display("txn %s: pulses=%0d at=%0d value=%0d", tag, pulses, pulse_at, val);
    endtask

    initial begin
        int exp_bits[8] = '{1, 1, 0, 1, 0, 1, 0, 1};
        int pulses, pulse_at, val;
        int p0, at0, v0, p1, at1, v1;
        int sw_cnt[4];

        // Reset with every input strobing.
        idle_inputs();
        bus.valid_in_dac = '1;
        bus.audio_in     = {16'd1000, 16'd20000};
        bus.valid_in_adc = '1;
        bus.sdm_in       = '1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_sdm", int'(bus.sdm_out), 0);
            check("rst_vdac", int'(bus.valid_out_dac), 0);
            check("rst_vadc", int'(bus.valid_out_adc), 0);
            check("rst_aout", int'(bus.audio_out), 0);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
        check("post_rst_sdm", int'(bus.sdm_out), 0);
        check("post_rst_vdac", int'(bus.valid_out_dac), 0);
        check("post_rst_vadc", int'(bus.valid_out_adc), 0);
        check("post_rst_aout", int'(bus.audio_out), 0);
        $display("txn reset: done");

        // Modulator, zero input on ch0 only.
        do_reset();
        bus.audio_in     = '0;
        bus.valid_in_dac = 2'b01;
        check("mod_vld_pre", int'(bus.valid_out_dac[0]), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("mod_bit", int'(bus.sdm_out[0]), exp_bits[k]);
            check("mod_vld", int'(bus.valid_out_dac[0]), 1);
            check("mod_ch1", int'({bus.valid_out_dac[1], bus.sdm_out[1]}), 0);
            $display("txn mod k=%0d sdm_out0=%0d", k, bus.sdm_out[0]);
        end
        bus.valid_in_dac = '0;
        tick();
        check("mod_vld_drop", int'(bus.valid_out_dac[0]), 0);
        check("mod_hold", int'(bus.sdm_out[0]), 1);

        // Demodulator extremes.
        demod_window("dm_ones", 0, 32767);
        demod_window("dm_zeros", 1, -32768);
        demod_window("dm_alt", 2, 0);

        // Partial window discarded by reset (strobe held through reset), then gapped strobes.
        do_reset();
        bus.valid_in_adc[0] = 1'b1;
        bus.sdm_in[0] = 1'b1;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0; pulse_at = -1; val = 0;
        for (int k = 0; k < 64; k++) begin
            bus.valid_in_adc[0] = 1'b1;
            tick();
            if (bus.valid_out_adc[0]) begin pulses++; if (pulse_at < 0) pulse_at = k; val = a0(); end
            bus.valid_in_adc[0] = 1'b0;
            tick();
            if (bus.valid_out_adc[0]) begin pulses++; if (pulse_at < 0) pulse_at = 100 + k; end
        end
        check("gap_pulses", pulses, 1);
        check("gap_at", pulse_at, 63);
        check("gap_val", val, 32767);
        $display("txn gapped: pulses=%0d at=%0d value=%0d", pulses, pulse_at, val);

        // Two channels with offset windows.
        idle_inputs();
        do_reset();
        p0 = 0; at0 = -1; v0 = 0; p1 = 0; at1 = -1; v1 = 0;
        for (int c = 0; c < 80; c++) begin
            bus.valid_in_adc[0] = (c < 64);
            bus.sdm_in[0]       = 1'b1;
            bus.valid_in_adc[1] = (c >= 10 && c < 74);
            bus.sdm_in[1]       = 1'b0;
            tick();
            if (bus.valid_out_adc[0]) begin p0++; at0 = c; v0 = a0(); end
            if (bus.valid_out_adc[1]) begin p1++; at1 = c; v1 = a1(); end
        end
        idle_inputs();
        check("off_ch0_pulses", p0, 1);
        check("off_ch0_at", at0, 63);
        check("off_ch0_val", v0, 32767);
        check("off_ch1_pulses", p1, 1);
        check("off_ch1_at", at1, 73);
        check("off_ch1_val", v1, -32768);
        $display("txn offset: ch0 at=%0d val=%0d ch1 at=%0d val=%0d", at0, v0, at1, v1);

`ifdef SDM_LOOPBACK_EN
        // Loopback: ch0 modulator at +0.5 FS feeding its own demodulator; external ADC inputs are noise.
        do_reset();
        loopback = 1'b1;
        bus.audio_in[15:0] = 16'd16384;
        bus.valid_in_dac[0] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 64 * 6; c++) begin
            bus.sdm_in       = 2'($urandom);
            bus.valid_in_adc = 2'($urandom);
            tick();
            if (bus.valid_out_adc[0]) begin
                pulses++;
                val = a0();
                if (pulses > 1) check("lb_in_range", int'(val >= 15360 && val <= 17408), 1);
                $display("txn loopback pulse=%0d value=%0d", pulses, val);
            end
        end
        check("lb_pulses", pulses, 5);
        loopback = 1'b0;
        idle_inputs();
`endif

        // 4x12-bit, DECIM=16 instance with all-ones input on every channel.
        do_reset();
        bus2.valid_in_adc = '1;
        bus2.sdm_in       = '1;
        for (int ch = 0; ch < 4; ch++) sw_cnt[ch] = 0;
        for (int c = 0; c < 48; c++) begin
            tick();
            for (int ch = 0; ch < 4; ch++) begin
                if (bus2.valid_out_adc[ch]) begin
                    logic signed [11:0] v;
                    v = bus2.audio_out[ch*12 +: 12];
                    sw_cnt[ch]++;
                    check("sw_val", int'(v), 2047);
                    check("sw_phase", c % 16, 15);
                    $display("txn sweep ch=%0d cycle=%0d value=%0d", ch, c, int'(v));
                end
            end
        end
        for (int ch = 0; ch < 4; ch++) check("sw_count", sw_cnt[ch], 3);
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
